winograd_tile_serializer: RTL and testbench

WINOGRAD_TILE_SERIALIZER -- requirements
Module: winograd_tile_serializer

---
 rtl/winograd_tile_serializer.sv | 185 ++++++++++++++++++
 tb/tb_winograd_tile_serializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_tile_serializer.sv
// rtl/winograd_tile_serializer.sv - captures a scaled Winograd tile and streams it element by element
//
// Purpose:
//   Takes a complete ROWS x COLS tile from the /576 division stage in one
//   cycle. It then emits the elements in row-major order over a valid/ready
//   stream. When the last element has been accepted, the block signals tile
//   completion and can capture the next tile.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_array   - scaled tile, indexed [row][col]
//   in_valid   - in_array holds a complete tile
//   in_ready   - block is idle and captures in_array when in_valid is high
//   out_data   - current streamed element (zero when not streaming)
//   out_row    - row index of out_data
//   out_col    - column index of out_data
//   out_last   - out_data is element [ROWS-1][COLS-1]
//   out_valid  - out_data/out_row/out_col/out_last are valid
//   out_ready  - consumer accepts the current element
//   tile_done  - one-cycle pulse after the last element of a tile is accepted
//   tile_count - number of completed tiles, wraps at 16 bits

module winograd_tile_serializer #(
    parameter int ROWS       = 8,
    parameter int COLS       = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]   in_array,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic [2:0]                                  out_row,
    output logic [3:0]                                  out_col,
    output logic                                        out_last,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        tile_done,
    output logic [15:0]                                 tile_count
);

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]  tile_q, tile_d;
    logic [2:0]                                 row_q, row_d;
    logic [3:0]                                 col_q, col_d;
    logic                                       tile_done_q, tile_done_d;
    logic [15:0]                                tile_count_q, tile_count_d;

    logic capture;
    logic accept;
    logic at_last_col;
    logic at_last_elem;

    assign capture      = (state_q == IDLE) && in_valid;
    assign accept       = (state_q == STREAM) && out_ready;
    assign at_last_col  = (col_q == LAST_COL);
    assign at_last_elem = at_last_col && (row_q == LAST_ROW);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The final handshake returns to IDLE. A new tile can be
                // taken at the earliest on the following edge.
                if (out_ready && at_last_elem) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = at_last_elem;
                out_data  = tile_q[row_q][col_q];
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    assign out_row    = row_q;
    assign out_col    = col_q;
    assign tile_done  = tile_done_q;
    assign tile_count = tile_count_q;

    // ---------------------------------------------------------------
    // Datapath next-state: tile storage, indices, completion tracking
    // ---------------------------------------------------------------
    always_comb begin
        tile_d       = tile_q;
        row_d        = row_q;
        col_d        = col_q;
        tile_done_d  = 1'b0;
        tile_count_d = tile_count_q;

        if (capture) begin
            tile_d = in_array;
            row_d  = 3'd0;
            col_d  = 4'd0;
        end

        if (accept) begin
            if (at_last_elem) begin
                row_d        = 3'd0;
                col_d        = 4'd0;
                tile_done_d  = 1'b1;
                // The count is registered on the same edge as the pulse, so
                // both become visible together in the cycle after the handshake.
                tile_count_d = tile_count_q + 16'd1;
            end else if (at_last_col) begin
                row_d = row_q + 3'd1;
                col_d = 4'd0;
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    // Control and index state. A reset clears it at once and abandons any
    // tile that is being streamed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= 3'd0;
            col_q        <= 4'd0;
            tile_done_q  <= 1'b0;
            tile_count_q <= 16'd0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            tile_done_q  <= tile_done_d;
            tile_count_q <= tile_count_d;
        end
    end

    // Tile storage needs no reset. out_data is forced to zero outside
    // STREAM, so stale contents never reach the output.
    always_ff @(posedge clk) begin
        tile_q <= tile_d;
    end

endmodule

// File: tb/tb_winograd_tile_serializer.sv
// tb/tb_winograd_tile_serializer.sv - directed self-checking bench for winograd_tile_serializer

module tb_winograd_tile_serializer;

    localparam int ROWS = 8;
    localparam int COLS = 10;
    localparam int DW   = 32;
    localparam int NELEM = ROWS * COLS;

    typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] tile_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tile_t       in_array;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [DW-1:0] out_data;
    logic [2:0]  out_row;
    logic [3:0]  out_col;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        tile_done;
    logic [15:0] tile_count;

    int          tests = 0;
    int          fails = 0;
    tile_t       exp_tile;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    winograd_tile_serializer #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_array   (in_array),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tile_done  (tile_done),
        .tile_count (tile_count)
    );

    // kind 0: r*16+c, kind 1: same with signed corner values, kind 2: distinct pattern
    function automatic tile_t make_tile(input int kind);
        tile_t t;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                case (kind)
                    2:       t[r][c] = 32'hA500_0000 + 32'(r * 256 + c * 3);
                    default: t[r][c] = 32'(r * 16 + c);
                endcase
            end
        end
        if (kind == 1) begin
            t[0][0] = 32'hFFFF_FFC0;
            t[ROWS-1][COLS-1] = 32'h8000_0000;
        end
        return t;
    endfunction

    task automatic capture(input tile_t t);
        @(negedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL capture_in_ready: got %0b expected 1", in_ready);
        end
        in_array = t;
        in_valid = 1'b1;
        @(posedge clk);
        exp_tile = t;
        #1;
        in_valid = 1'b0;
        // Change the input after capture: the stored tile must not follow it.
        in_array = ~t;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1
    task automatic stream_check(input int mode, input int stop_after, output int cycles);
        int idx = 0;
        int r;
        int c;
        bit first = 1'b1;
        bit abort = 1'b0;
        bit stalled = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic [2:0] prev_r = '0;
        logic [3:0] prev_c = '0;
        cycles = 0;
        while (idx < stop_after && cycles < 4000 && !abort) begin
            @(negedge clk);
            if (mode == 1) out_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
            else           out_ready = 1'b1;
            #1;
            if (first) begin
                first = 1'b0;
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL latency: out_valid got %0b expected 1 one cycle after capture", out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                r = idx / COLS;
                c = idx % COLS;
                tests++;
                if (out_data !== exp_tile[r][c] || out_row !== 3'(r) || out_col !== 4'(c) ||
                    out_last !== 1'(idx == NELEM - 1) || in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL element %0d: got data=%h row=%0d col=%0d last=%0b in_ready=%0b expected data=%h row=%0d col=%0d last=%0b in_ready=0",
                             idx, out_data, out_row, out_col, out_last, in_ready,
                             exp_tile[r][c], r, c, (idx == NELEM - 1));
                end
                if (stalled) begin
                    tests++;
                    if (out_data !== prev_d || out_row !== prev_r || out_col !== prev_c) begin
                        fails++;
                        $display("FAIL stall_hold %0d: got %h/%0d/%0d expected %h/%0d/%0d",
                                 idx, out_data, out_row, out_col, prev_d, prev_r, prev_c);
                    end
                end
                stalled = !out_ready;
                prev_d  = out_data;
                prev_r  = out_row;
                prev_c  = out_col;
                if (out_ready) idx++;
            end else begin
                tests++;
                fails++;
                $display("FAIL out_valid_drop at element %0d: got %0b expected 1", idx, out_valid);
                abort = 1'b1;
            end
            cycles++;
        end
        if (idx < stop_after && !abort) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d elements expected %0d", idx, stop_after);
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        exp_count = exp_count + 16'd1;
        tests++;
        if (tile_done !== 1'b1) begin
            fails++;
            $display("FAIL tile_done_pulse: got %0b expected 1", tile_done);
        end
        tests++;
        if (tile_count !== exp_count) begin
            fails++;
            $display("FAIL tile_count: got %0d expected %0d", tile_count, exp_count);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_row !== 3'd0 || out_col !== 4'd0) begin
            fails++;
            $display("FAIL return_idle: got in_ready=%0b out_valid=%0b row=%0d col=%0d expected 1 0 0 0",
                     in_ready, out_valid, out_row, out_col);
        end
        @(negedge clk);
        #1;
        tests++;
        if (tile_done !== 1'b0) begin
            fails++;
            $display("FAIL tile_done_width: got %0b expected 0", tile_done);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_array = make_tile(0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || tile_done !== 1'b0 ||
            out_row !== 3'd0 || out_col !== 4'd0 || out_data !== 32'd0 || tile_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: got in_ready=%0b out_valid=%0b last=%0b done=%0b row=%0d col=%0d data=%h count=%0d expected 1 0 0 0 0 0 0 0",
                     in_ready, out_valid, out_last, tile_done, out_row, out_col, out_data, tile_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        capture(make_tile(0));
        stream_check(0, NELEM, cyc);
        tests++;
        if (cyc + 1 !== NELEM + 1) begin
            fails++;
            $display("FAIL throughput: got %0d cycles expected %0d", cyc + 1, NELEM + 1);
        end
        check_done();
    endtask

    task automatic test_backpressure();
        int cyc;
        capture(make_tile(2));
        stream_check(1, NELEM, cyc);
        check_done();
    endtask

    task automatic test_negative();
        int cyc;
        capture(make_tile(1));
        stream_check(0, NELEM, cyc);
        check_done();
    endtask

    task automatic test_ignored_input();
        int cyc;
        tile_t second;
        second = make_tile(2);
        capture(make_tile(0));
        in_array = second;
        in_valid = 1'b1;
        stream_check(0, NELEM, cyc);
        check_done();
        // The held in_valid is taken on the edge after the idle cycle.
        exp_tile = second;
        in_valid = 1'b0;
        stream_check(0, NELEM, cyc);
        check_done();
    endtask

    task automatic test_midstream_reset();
        int cyc;
        capture(make_tile(2));
        stream_check(0, 37, cyc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 16'd0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || tile_count !== 16'd0 ||
            out_data !== 32'd0 || out_row !== 3'd0 || out_col !== 4'd0 || tile_done !== 1'b0) begin
            fails++;
            $display("FAIL midstream_reset: got valid=%0b in_ready=%0b count=%0d data=%h row=%0d col=%0d done=%0b expected 0 1 0 0 0 0 0",
                     out_valid, in_ready, tile_count, out_data, out_row, out_col, tile_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(make_tile(0));
        stream_check(0, NELEM, cyc);
        check_done();
    endtask

    task automatic test_wrap();
        int cyc;
        @(negedge clk);
        force dut.tile_count_q = 16'hFFFF;
        #1;
        release dut.tile_count_q;
        @(posedge clk);
        #1;
        exp_count = 16'hFFFF;
        tests++;
        if (tile_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload: got %0d expected 65535", tile_count);
        end
        capture(make_tile(1));
        stream_check(0, NELEM, cyc);
        check_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_negative();
        test_ignored_input();
        test_midstream_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
